des_sbox_unit: RTL and testbench

DES_SBOX_UNIT -- requirements
Module: des_sbox_unit

---
 rtl/des_sbox_unit_if.sv | 16 +
 rtl/des_sbox_unit.sv | 110 +++++++++++
 tb/tb_des_sbox_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/des_sbox_unit_if.sv
// Handshake bundle for des_sbox_unit: 48-bit block in, 32-bit substituted result out.
// The slave side is the S-box unit and the master side is its driver and consumer.
interface des_sbox_unit_if;
   logic        valid_i;
   logic        ready_o;
   logic [47:0] block_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] block_o;
   logic        busy_o;

   modport slave  (input  valid_i, block_i, ready_i,
                   output ready_o, valid_o, block_o, busy_o);
   modport master (output valid_i, block_i, ready_i,
                   input  ready_o, valid_o, block_o, busy_o);
endinterface

// File: rtl/des_sbox_unit.sv
// DES S-box layer. It evaluates BOXES_PER_CYCLE boxes per cycle, so the result is valid ITERS cycles after capture.
// It accepts a block only when IDLE and holds the result in DONE until ready_i is high.
module des_sbox_unit #(
   parameter int BOXES_PER_CYCLE = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   des_sbox_unit_if.slave bus
);
   localparam int ITERS = 8 / BOXES_PER_CYCLE;
   localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   // Each box table is laid out row-major: entry index = 16*row + col.
   localparam logic [3:0] SBOX [8][64] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
   };

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [47:0]      r_blk;
   logic [31:0]      r_res;
   logic [31:0]      w_res;
   logic [2:0]       w_k;
   logic [5:0]       w_c;
   logic             w_last;
   logic             w_take;

   assign w_last = (r_cnt == CNT_W'(ITERS - 1));
   assign w_take = (r_state == IDLE) && bus.valid_i;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.valid_i) w_next = BUSY;
         BUSY:    if (w_last)      w_next = DONE;
         DONE:    if (bus.ready_i) w_next = IDLE;
         default:                  w_next = IDLE;
      endcase
   end

   // Only the nibbles of the boxes in the current slice are rewritten. The other nibbles keep their value.
   always_comb begin
      w_res = r_res;
      w_k   = 3'd0;
      w_c   = 6'd0;
      for (int j = 0; j < BOXES_PER_CYCLE; j++) begin
         w_k = 3'(int'(r_cnt) * BOXES_PER_CYCLE + j);
         w_c = r_blk[6 * (7 - int'(w_k)) +: 6];
         w_res[4 * (7 - int'(w_k)) +: 4] = SBOX[w_k][{w_c[5], w_c[0], w_c[4:1]}];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_blk   <= '0;
         r_res   <= '0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_blk <= bus.block_i;
            r_cnt <= '0;
         end
         if (r_state == BUSY) begin
            r_res <= w_res;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         end
      end
   end

   assign bus.ready_o = (r_state == IDLE);
   assign bus.valid_o = (r_state == DONE);
   assign bus.busy_o  = (r_state != IDLE);
   assign bus.block_o = r_res;
endmodule

// File: tb/tb_des_sbox_unit.sv
// Runs four des_sbox_unit instances, one for each BOXES_PER_CYCLE value (1/2/4/8), side by side.
// Results are compared through a per-instance scoreboard against a reference S-box model.
module tb_des_sbox_unit;
   localparam logic [3:0] ST [8][4][16] = '{
      '{'{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7},
        '{ 0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8},
        '{ 4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0},
        '{15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13}},
      '{'{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10},
        '{ 3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5},
        '{ 0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15},
        '{13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9}},
      '{'{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8},
        '{13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1},
        '{13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7},
        '{ 1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12}},
      '{'{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15},
        '{13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9},
        '{10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4},
        '{ 3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14}},
      '{'{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9},
        '{14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6},
        '{ 4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14},
        '{11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3}},
      '{'{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11},
        '{10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8},
        '{ 9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6},
        '{ 4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13}},
      '{'{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1},
        '{13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6},
        '{ 1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2},
        '{ 6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12}},
      '{'{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7},
        '{ 1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2},
        '{ 7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8},
        '{ 2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}}
   };

   localparam int N_RND = 250;

   logic        clk;
   logic        rst;
   logic [3:0]  t_valid;
   logic [3:0]  t_rdy;
   logic [47:0] t_blk [4];
   logic [3:0]  o_rdy;
   logic [3:0]  o_vld;
   logic [3:0]  o_busy;
   logic [31:0] o_blk [4];

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] sb_q [4][$];
   int          sent [4];
   int          got  [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      des_sbox_unit_if u_if ();
      des_sbox_unit #(.BOXES_PER_CYCLE(1 << g)) u_dut (
         .clk_i (clk),
         .rst_i (rst),
         .bus   (u_if)
      );
      assign u_if.valid_i = t_valid[g];
      assign u_if.block_i = t_blk[g];
      assign u_if.ready_i = t_rdy[g];
      assign o_rdy[g]     = u_if.ready_o;
      assign o_vld[g]     = u_if.valid_o;
      assign o_busy[g]    = u_if.busy_o;
      assign o_blk[g]     = u_if.block_o;
   end

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_sbox(input logic [47:0] b);
      logic [5:0]  c;
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         c = b[47 - 6 * k -: 6];
         r[31 - 4 * k -: 4] = ST[3'(k)][{c[5], c[0]}][c[4:1]];
      end
      return r;
   endfunction

   // Pushes one block through instance i with ready_i held high.
   // Checks the latency from capture to valid_o, the result, and busy_o over the whole transaction.
   task automatic xfer(input int i, input logic [47:0] blk, input logic [31:0] exp, input string tag);
      int   n;
      logic busy_ok;
      t_blk[i]   = blk;
      t_valid[i] = 1'b1;
      t_rdy[i]   = 1'b1;
      @(negedge clk);
      t_valid[i] = 1'b0;
      n       = 0;
      busy_ok = 1'b1;
      while (!o_vld[i] && n < 20) begin
         if (!o_busy[i]) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      chk($sformatf("%s%0d_lat", tag, i), 48'(n), 48'(8 >> i));
      chk($sformatf("%s%0d_dat", tag, i), 48'(o_blk[i]), 48'(exp));
      chk($sformatf("%s%0d_busy", tag, i), 48'(busy_ok && o_busy[i]), 48'd1);
      @(negedge clk);
      chk($sformatf("%s%0d_idle", tag, i), 48'({o_rdy[i], o_vld[i], o_busy[i]}), 48'b100);
   endtask

   initial begin
      int          cyc;
      int          n;
      logic        seen;
      logic [31:0] e;

      rst     = 1'b1;
      t_valid = '0;
      t_rdy   = '0;
      for (int i = 0; i < 4; i++) begin
         t_blk[i] = '0;
         sent[i]  = 0;
         got[i]   = 0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst%0d_flags", i), 48'({o_rdy[i], o_vld[i], o_busy[i]}), 48'b100);
         chk($sformatf("rst%0d_blk", i), 48'(o_blk[i]), 48'h0);
      end
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         xfer(i, 48'h0, 32'hEFA72C4D, "zero");
         xfer(i, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, "ones");
         xfer(i, {6'b011011, 42'b0}, 32'h5FA72C4D, "box1_");
         xfer(i, 48'h1234_5678_9ABC, ref_sbox(48'h1234_5678_9ABC), "mix");
      end

      // Output stall on the BOXES_PER_CYCLE=2 instance while the inputs are toggled.
      t_blk[1]   = 48'hA5A5_3C3C_0F0F;
      t_valid[1] = 1'b1;
      t_rdy[1]   = 1'b0;
      e          = ref_sbox(48'hA5A5_3C3C_0F0F);
      @(negedge clk);
      t_valid[1] = 1'b0;
      n = 0;
      while (!o_vld[1] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stall_lat", 48'(n), 48'd4);
      for (int s = 0; s < 10; s++) begin
         t_blk[1]   = {16'($urandom()), $urandom()};
         t_valid[1] = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk($sformatf("stall_c%0d", s), 48'({o_vld[1], o_rdy[1], o_blk[1]}), 48'({2'b10, e}));
      end
      t_valid[1] = 1'b0;
      t_rdy[1]   = 1'b1;
      @(negedge clk);
      chk("stall_release", 48'({o_rdy[1], o_vld[1]}), 48'b10);

      // Reset arrives on the edge that would perform iteration 2 of the BOXES_PER_CYCLE=1 instance.
      t_blk[0]   = 48'hFFFF_FFFF_FFFF;
      t_valid[0] = 1'b1;
      t_rdy[0]   = 1'b1;
      @(negedge clk);
      t_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_flags", 48'({o_rdy[0], o_vld[0], o_busy[0]}), 48'b100);
      chk("midrst_blk", 48'(o_blk[0]), 48'h0);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (o_vld[0]) seen = 1'b1;
      end
      chk("midrst_noresult", 48'(seen), 48'd0);

      // Random traffic with random stalls on all four instances at once.
      cyc = 0;
      while ((got[0] < N_RND || got[1] < N_RND || got[2] < N_RND || got[3] < N_RND) && cyc < 30000) begin
         for (int i = 0; i < 4; i++) begin
            t_rdy[i] = ($urandom_range(0, 2) != 0);
            if (o_vld[i] && t_rdy[i]) begin
               if (sb_q[i].size() == 0) begin
                  chk($sformatf("rnd%0d_extra", i), 48'd1, 48'd0);
               end else begin
                  e = sb_q[i].pop_front();
                  chk($sformatf("rnd%0d_n%0d", i, got[i]), 48'(o_blk[i]), 48'(e));
                  got[i]++;
               end
            end
            t_blk[i]   = {16'($urandom()), $urandom()};
            t_valid[i] = (sent[i] < N_RND) && ($urandom_range(0, 1) == 1);
            if (o_rdy[i] && t_valid[i]) begin
               sb_q[i].push_back(ref_sbox(t_blk[i]));
               sent[i]++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      t_valid = '0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rnd%0d_count", i), 48'(got[i]), 48'(N_RND));
         chk($sformatf("rnd%0d_left", i), 48'(sb_q[i].size()), 48'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
